// File: rtl/bus_xfer_ctrl.sv
// ============================================================================
// Module   : bus_xfer_ctrl
// Purpose  : Contention-free move sequencer for the shared 8-bit register bus.
//            Optional 4-deep command FIFO enabled by BUS_XFER_CTRL_FIFO_EN.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bus_xfer_ctrl #(
    parameter int NREG = 4,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_imm,
    input  logic [SELW-1:0] cmd_src,
    input  logic [SELW-1:0] cmd_dst,
    input  logic [7:0]      cmd_data,
    output logic [NREG-1:0] reg_en,
    output logic [NREG-1:0] reg_ld,
    output logic [7:0]      bus,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int            CW      = 1 + 2*SELW + 8;
    localparam logic [1:0]    c_IDLE  = 2'd0;
    localparam logic [1:0]    c_DRIVE = 2'd1;
    localparam logic [1:0]    c_LOAD  = 2'd2;
    localparam logic [SELW:0] c_NREG  = (SELW+1)'(NREG);

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic            r_imm;
    logic [SELW-1:0] r_src;
    logic [SELW-1:0] r_dst;
    logic [7:0]      r_data;
    logic            r_drop;

    logic            w_take;
    logic            w_accept;
    logic            w_avail;
    logic            w_latch;
    logic            w_legal;
    logic            w_q_nonempty;
    logic [CW-1:0]   w_in;
    logic [CW-1:0]   w_cand;
    logic            w_c_imm;
    logic [SELW-1:0] w_c_src;
    logic [SELW-1:0] w_c_dst;
    logic [7:0]      w_c_data;
    logic            w_drive;

    // A new command can only be latched when no source is being held for
    // an unfinished transfer: in IDLE or in the final (LOAD) cycle.
    assign w_take   = (r_state == c_IDLE) || (r_state == c_LOAD);
    assign w_accept = cmd_valid && cmd_ready;
    assign w_in     = {cmd_imm, cmd_src, cmd_dst, cmd_data};

`ifdef BUS_XFER_CTRL_FIFO_EN
    logic [CW-1:0] r_fifo [4];
    logic [1:0]    r_wr;
    logic [1:0]    r_rd;
    logic [2:0]    r_cnt;
    logic          w_pop;
    logic          w_push;

    assign w_q_nonempty = (r_cnt != 3'd0);
    assign cmd_ready    = (r_cnt != 3'd4) || w_take;
    assign w_avail      = w_q_nonempty || w_accept;
    assign w_cand       = w_q_nonempty ? r_fifo[r_rd] : w_in;
    assign w_pop        = w_take && w_q_nonempty;
    // An empty queue lets an accepted command bypass straight into the slot.
    assign w_push       = w_accept && !(w_take && !w_q_nonempty);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr] <= w_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= 2'd0;
            r_rd  <= 2'd0;
            r_cnt <= 3'd0;
        end else begin
            if (w_push) r_wr <= r_wr + 2'd1;
            if (w_pop)  r_rd <= r_rd + 2'd1;
            r_cnt <= r_cnt + {2'b00, w_push} - {2'b00, w_pop};
        end
    end
`else
    assign w_q_nonempty = 1'b0;
    assign cmd_ready    = w_take;
    assign w_avail      = w_accept;
    assign w_cand       = w_in;
`endif

    assign w_c_imm  = w_cand[CW-1];
    assign w_c_src  = w_cand[CW-2 -: SELW];
    assign w_c_dst  = w_cand[8+SELW-1 -: SELW];
    assign w_c_data = w_cand[7:0];

    assign w_legal = ({1'b0, w_c_dst} < c_NREG) &&
                     (w_c_imm || (({1'b0, w_c_src} < c_NREG) && (w_c_src != w_c_dst)));
    assign w_latch = w_take && w_avail;

    // State register and command slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_imm   <= 1'b0;
            r_src   <= '0;
            r_dst   <= '0;
            r_data  <= 8'h00;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_drop  <= w_latch && !w_legal;
            if (w_latch) begin
                r_imm  <= w_c_imm;
                r_src  <= w_c_src;
                r_dst  <= w_c_dst;
                r_data <= w_c_data;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = c_IDLE;
        case (r_state)
            c_IDLE:  w_next = (w_avail && w_legal) ? c_DRIVE : c_IDLE;
            c_DRIVE: w_next = c_LOAD;
            c_LOAD:  w_next = (w_avail && w_legal) ? c_DRIVE : c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Output decode
    assign w_drive = (r_state == c_DRIVE) || (r_state == c_LOAD);

    always_comb begin
        reg_en = '0;
        reg_ld = '0;
        for (int i = 0; i < NREG; i++) begin
            reg_en[i] = w_drive && !r_imm && (r_src == SELW'(i));
            reg_ld[i] = (r_state == c_LOAD) && (r_dst == SELW'(i));
        end
        done = (r_state == c_LOAD) || r_drop;
        err  = r_drop;
        busy = (r_state != c_IDLE) || w_q_nonempty;
    end

    assign bus = (w_drive && r_imm) ? r_data : 8'bz;

endmodule

`default_nettype wire

// File: tb/tb_bus_xfer_ctrl.sv
// ============================================================================
// Module   : tb_bus_xfer_ctrl
// Purpose  : Directed self-checking bench for bus_xfer_ctrl with a 4-register
//            bank model attached to reg_en / reg_ld / bus.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bus_xfer_ctrl;

    localparam int NREG = 4;
    localparam int SELW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_imm;
    logic [SELW-1:0] cmd_src;
    logic [SELW-1:0] cmd_dst;
    logic [7:0]      cmd_data;
    logic [NREG-1:0] reg_en;
    logic [NREG-1:0] reg_ld;
    wire  [7:0]      bus;
    logic            busy;
    logic            done;
    logic            err;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int viol  = 0;
    int err_cnt = 0;
    int done_q [$];

    logic [7:0] regs [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] src_val;

    bus_xfer_ctrl #(.NREG(NREG), .SELW(SELW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_imm   (cmd_imm),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_data  (cmd_data),
        .reg_en    (reg_en),
        .reg_ld    (reg_ld),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Register bank: the enabled register (or the immediate driver) feeds the bus
    always_comb begin
        src_val = bus;
        for (int i = 0; i < NREG; i++) begin
            if (reg_en[i]) src_val = regs[i];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NREG; i++) begin
            if (reg_ld[i]) regs[i] <= src_val;
        end
    end

    always @(negedge clk) begin
        if ($countones(reg_en) > 1 || $countones(reg_ld) > 1) viol <= viol + 1;
        if (done) done_q.push_back(cyc);
        if (err) err_cnt <= err_cnt + 1;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until the edge that accepts it;
    // returns one step after that edge (the DRIVE cycle for a legal command).
    task automatic send(input logic imm, input logic [SELW-1:0] src,
                        input logic [SELW-1:0] dst, input logic [7:0] data);
        int n;
        cmd_imm = imm; cmd_src = src; cmd_dst = dst; cmd_data = data;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check_vec("send_timeout", 32'(n), 32'd0);
        tick();
        cmd_valid = 1'b0;
    endtask

    logic            b_imm [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [SELW-1:0] b_src [4] = '{3'd0, 3'd3, 3'd0, 3'd1};
    logic [SELW-1:0] b_dst [4] = '{3'd1, 3'd0, 3'd2, 3'd3};
    logic [7:0]      b_dat [4] = '{8'h00, 8'h00, 8'h5A, 8'h00};

    initial begin
        int d0;
        int e0;
        int n;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_imm = 1'b0;
        cmd_src = '0; cmd_dst = '0; cmd_data = 8'h00;
        tick(); tick();
        check_vec("rst_en",   32'(reg_en), 32'h0);
        check_vec("rst_ld",   32'(reg_ld), 32'h0);
        check_vec("rst_busy", 32'(busy),   32'h0);
        check_vec("rst_done", 32'({done, err}), 32'h0);
        rst_n = 1'b1;
        tick();
        check_vec("rst_ready", 32'(cmd_ready), 32'h1);

        // Register move r1 -> r2
        send(1'b0, 3'd1, 3'd2, 8'h00);
        check_vec("mv_en_drive", 32'(reg_en), 32'h2);
        check_vec("mv_ld_drive", 32'(reg_ld), 32'h0);
        check_vec("mv_busy",     32'(busy),   32'h1);
        tick();
        check_vec("mv_en_load",  32'(reg_en), 32'h2);
        check_vec("mv_ld_load",  32'(reg_ld), 32'h4);
        check_vec("mv_done",     32'({done, err}), 32'h2);
        tick();
        check_vec("mv_idle",     32'({reg_en, reg_ld, 1'b0, done, busy}), 32'h0);
        check_vec("mv_reg2",     32'(regs[2]), 32'h22);

        // Immediate A5 -> r3
        send(1'b1, 3'd0, 3'd3, 8'hA5);
        check_vec("imm_en",      32'(reg_en), 32'h0);
        check_vec("imm_bus1",    32'(bus),    32'hA5);
        tick();
        check_vec("imm_bus2",    32'(bus),    32'hA5);
        check_vec("imm_ld",      32'(reg_ld), 32'h8);
        check_vec("imm_done",    32'(done),   32'h1);
        tick();
        check_vec("imm_release", 32'(bus === 8'hA5), 32'h0);
        check_vec("imm_reg3",    32'(regs[3]), 32'hA5);

        // Illegal: src == dst, then dst out of range
        send(1'b0, 3'd1, 3'd1, 8'h00);
        check_vec("ill1_pulse",  32'({done, err}), 32'h3);
        check_vec("ill1_quiet",  32'({reg_en, reg_ld}), 32'h0);
        tick();
        check_vec("ill1_end",    32'({done, err}), 32'h0);
        send(1'b0, 3'd0, 3'd5, 8'h00);
        check_vec("ill2_pulse",  32'({done, err}), 32'h3);
        check_vec("ill2_quiet",  32'({reg_en, reg_ld}), 32'h0);
        tick();
        check_vec("ill2_end",    32'({done, err, reg_ld}), 32'h0);
        check_vec("ill_regs",    32'({regs[0], regs[1], regs[2], regs[3]}), 32'h112222A5);

        // Back-to-back: r0->r1, r3->r0, imm 5A->r2, r1->r3
        d0 = done_q.size();
        e0 = err_cnt;
`ifdef BUS_XFER_CTRL_FIFO_EN
        for (int k = 0; k < 4; k++) begin
            cmd_imm = b_imm[k]; cmd_src = b_src[k]; cmd_dst = b_dst[k]; cmd_data = b_dat[k];
            cmd_valid = 1'b1;
            check_vec("b2b_ready", 32'(cmd_ready), 32'h1);
            tick();
        end
        cmd_valid = 1'b0;
`else
        for (int k = 0; k < 4; k++) begin
            send(b_imm[k], b_src[k], b_dst[k], b_dat[k]);
        end
`endif
        n = 0;
        while (done_q.size() < d0 + 4 && n < 30) begin
            tick();
            n++;
        end
        check_vec("b2b_done_cnt", 32'(done_q.size() - d0), 32'd4);
        if (done_q.size() >= d0 + 4) begin
            for (int k = 1; k < 4; k++) begin
                check_vec("b2b_gap", 32'(done_q[d0+k] - done_q[d0+k-1]), 32'd2);
            end
        end
        check_vec("b2b_err",  32'(err_cnt - e0), 32'd0);
        check_vec("b2b_regs", 32'({regs[0], regs[1], regs[2], regs[3]}), 32'hA5115A11);
        check_vec("b2b_busy", 32'(busy), 32'h0);

        // Reset during LOAD, with a second command offered behind it
        send(1'b0, 3'd2, 3'd0, 8'h00);
        cmd_imm = 1'b0; cmd_src = 3'd1; cmd_dst = 3'd0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check_vec("rm_ld_load", 32'(reg_ld), 32'h1);
        d0 = done_q.size();
        #1 rst_n = 1'b0;
        #1;
        check_vec("rm_en",   32'(reg_en), 32'h0);
        check_vec("rm_ld",   32'(reg_ld), 32'h0);
        check_vec("rm_busy", 32'(busy),   32'h0);
        check_vec("rm_bus",  32'(bus === 8'h5A), 32'h0);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        check_vec("rm_no_done", 32'(done_q.size() - d0), 32'd0);
        check_vec("rm_idle",    32'({busy, cmd_ready}), 32'h1);
        check_vec("rm_reg0",    32'(regs[0]), 32'hA5);

        check_vec("onehot_viol", 32'(viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_xfer_ctrl.md
# bus_xfer_ctrl

Sequencer for the shared 8-bit tri-state register bus. It accepts register-to-register or immediate-to-register move commands over a valid/ready port, drives exactly one bus source at a time via the registers' `enable` inputs, and strobes the destination's `load`. It sits between the instruction decoder and the bank of 8-bit bus registers, and guarantees contention-free transfers.

## Interface
- `NREG`, 4: number of bus registers controlled (2..8).
- `SELW`, 2: width of register index fields; must satisfy 2^SELW ≥ NREG.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when high with `cmd_valid` at posedge
- `cmd_imm`  in  1  1 = source is `cmd_data`, 0 = source is register `cmd_src`
- `cmd_src`  in  SELW  source register index (ignored if `cmd_imm`)
- `cmd_dst`  in  SELW  destination register index
- `cmd_data`  in  8  immediate value
- `reg_en`  out  NREG  one-hot bus-drive enables, to register `enable`
- `reg_ld`  out  NREG  one-hot load strobes, to register `load`
- `bus`  out  8  immediate driver; 8'bz when not driving an immediate
- `busy`  out  1  transfer in progress or queued
- `done`  out  1  one-cycle pulse per completed or dropped command
- `err`  out  1  one-cycle pulse, coincident with `done`, for illegal commands

## Operation
- FSM states: IDLE, DRIVE, LOAD.
- IDLE: if a command is available (accepted this cycle or queued), latch it and go to DRIVE; else stay.
- DRIVE (1 cycle): assert `reg_en[src]` (or drive `bus` = latched `cmd_data` if imm); all `reg_ld` = 0. Bus settle cycle.
- LOAD (1 cycle): keep same source drive; assert `reg_ld[dst]`. Destination captures on the posedge ending LOAD. Pulse `done` in this cycle. Next state DRIVE if another command is pending, else IDLE.
- Illegal commands, checked when latched in IDLE/LOAD: `cmd_dst` ≥ NREG, or (not imm and `cmd_src` ≥ NREG), or (not imm and `cmd_src` == `cmd_dst`). Dropped: no enable, no load; `done` and `err` pulse together the cycle after latch; FSM stays/returns IDLE.
- Invariants: at most one bit of `reg_en` high; `reg_en` never high while `bus` is driven; at most one bit of `reg_ld` high; `reg_ld` only in LOAD.
- `busy` = state ≠ IDLE or queue non-empty.

## Timing
- Reset (async, immediate): state IDLE, `reg_en` = 0, `reg_ld` = 0, `bus` = 8'bz, `done` = 0, `err` = 0, `busy` = 0, queue flushed; `cmd_ready` = 1 after release. Reset mid-transfer aborts with no load.
- Latency: command accepted at edge N → DRIVE in cycle N+1 → LOAD in N+2 → destination holds data after edge N+3.
- Back-to-back throughput: one transfer per 2 cycles; source enable switches directly from one register to the next at the LOAD→DRIVE edge.
- `cmd_ready` is combinational from internal state only, never from `cmd_valid`.

## Configuration
- `BUS_XFER_CTRL_FIFO_EN` defined: 4-entry command FIFO; `cmd_ready` = FIFO not full; accept and pop may occur in the same cycle; full FIFO with simultaneous pop accepts.
- Undefined: single holding slot; `cmd_ready` = 1 only in IDLE, or in LOAD of the last pending transfer; no queueing.

## Test plan
- Reg move: after reset, cmd src=1, dst=2, imm=0 → `reg_en`=4'b0010 for 2 cycles, `reg_ld`=4'b0100 in 2nd, `done` pulse at N+2, register 2 holds register 1's value.
- Immediate: cmd imm=1, data=8'hA5, dst=3 → `reg_en`=0, `bus`=8'hA5 for 2 cycles then 8'bz, register 3 = 8'hA5.
- Back-to-back (FIFO_EN): 4 commands on consecutive cycles → `cmd_ready` never drops, 4 `done` pulses 2 cycles apart, `reg_en` never two-hot.
- Illegal: src=dst=1 and dst=5 with NREG=4 → `done`+`err` pulse each, `reg_ld` stays 0.
- Reset mid-transfer: assert `rst_n`=0 during LOAD → `reg_en`, `reg_ld` = 0 same cycle, `bus`=8'bz, `busy`=0, queued commands discarded.
